// File: rtl/axi_lite_apb_bridge_n.sv
// AXI4-Lite slave to APB master bridge with NUM_SLAVES one-hot selected APB targets.
// One transfer in flight at a time; reads and writes alternate when both are pending.
module axi_lite_apb_bridge_n #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_SLAVES    = 4,
    parameter int unsigned SLV_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned TIMEOUT       = 16,
    localparam int unsigned STRB_W       = DATA_WIDTH / 8,
    localparam int unsigned IDXW         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [ADDR_WIDTH-1:0]            AWADDR,
    input  logic                             AWVALID,
    output logic                             AWREADY,
    input  logic [DATA_WIDTH-1:0]            WDATA,
    input  logic [STRB_W-1:0]                WSTRB,
    input  logic                             WVALID,
    output logic                             WREADY,
    output logic [1:0]                       BRESP,
    output logic                             BVALID,
    input  logic                             BREADY,
    input  logic [ADDR_WIDTH-1:0]            ARADDR,
    input  logic                             ARVALID,
    output logic                             ARREADY,
    output logic [DATA_WIDTH-1:0]            RDATA,
    output logic [1:0]                       RRESP,
    output logic                             RVALID,
    input  logic                             RREADY,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [STRB_W-1:0]                PSTRB,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR,
    output logic                             error
);

    localparam int unsigned CNTW  = $clog2(TIMEOUT + 1);
    localparam int unsigned TAGLO = SLV_ADDR_BITS + IDXW;
    localparam logic [IDXW:0]     NumSlv    = NUM_SLAVES[IDXW:0];
    localparam logic [CNTW-1:0]   TimeoutC  = TIMEOUT[CNTW-1:0];
    localparam logic [1:0]        RespOkay  = 2'b00;
    localparam logic [1:0]        RespSlvErr = 2'b10;
    localparam logic [1:0]        RespDecErr = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                  state_q, state_d;
    logic                    last_wr_q, last_wr_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [1:0]              resp_q, resp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic                    error_q, error_d;

    logic                    wr_req, rd_req;
    logic                    grant_wr, grant_rd;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [IDXW-1:0]         req_idx;
    logic                    req_hit;
    logic                    sel_ready, sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    apb_phase;

    // Grants only exist in IDLE; on contention the type not granted last time wins.
    always_comb begin
        wr_req   = AWVALID && WVALID;
        rd_req   = ARVALID;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == StIdle && !ARESET) begin
            if (wr_req && rd_req) begin
                grant_wr = !last_wr_q;
                grant_rd = last_wr_q;
            end else begin
                grant_wr = wr_req;
                grant_rd = rd_req;
            end
        end
    end

    assign req_addr = grant_wr ? AWADDR : ARADDR;
    assign req_idx  = req_addr[SLV_ADDR_BITS +: IDXW];
    assign req_hit  = (req_addr[ADDR_WIDTH-1:TAGLO] == BASE_ADDR[ADDR_WIDTH-1:TAGLO]) &&
                      ({1'b0, req_idx} < NumSlv);

    always_comb begin
        sel_ready = PREADY[idx_q];
        sel_err   = PSLVERR[idx_q];
        sel_rdata = PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        idx_d     = idx_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        error_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_wr || grant_rd) begin
                    last_wr_d = grant_wr;
                    write_d   = grant_wr;
                    addr_d    = req_addr;
                    idx_d     = req_idx;
                    if (grant_wr) begin
                        wdata_d = WDATA;
                        strb_d  = WSTRB;
                    end else begin
                        strb_d = '0;
                    end
                    if (req_hit) begin
                        state_d = StSetup;
                    end else begin
                        // Unmapped: answer directly, never touch the APB side.
                        state_d = StResp;
                        resp_d  = RespDecErr;
                        rdata_d = '0;
                        error_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = CNTW'(1);
            end
            StAccess: begin
                if (sel_ready) begin
                    state_d = StResp;
                    resp_d  = sel_err ? RespSlvErr : RespOkay;
                    error_d = sel_err;
                    if (!write_q) begin
                        rdata_d = sel_rdata;
                    end
                end else if (cnt_q == TimeoutC) begin
                    state_d = StResp;
                    resp_d  = RespSlvErr;
                    rdata_d = '0;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if ((write_q && BREADY) || (!write_q && RREADY)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= StIdle;
            last_wr_q <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            idx_q     <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            error_q   <= error_d;
        end
    end

    assign apb_phase = (state_q == StSetup) || (state_q == StAccess);

    always_comb begin
        PSEL = '0;
        if (apb_phase) begin
            PSEL[idx_q] = 1'b1;
        end
    end

    assign AWREADY = grant_wr;
    assign WREADY  = grant_wr;
    assign ARREADY = grant_rd;
    assign BVALID  = (state_q == StResp) && write_q;
    assign RVALID  = (state_q == StResp) && !write_q;
    assign BRESP   = resp_q;
    assign RRESP   = resp_q;
    assign RDATA   = rdata_q;
    assign PENABLE = (state_q == StAccess);
    assign PWRITE  = apb_phase && write_q;
    assign PADDR   = addr_q;
    assign PWDATA  = wdata_q;
    assign PSTRB   = strb_q;
    assign error   = error_q;

endmodule
